// File: rtl/frame_sample_buffer_pkg.sv
// Shared constants for frame_sample_buffer: register map, STATUS/CONTROL bit
// positions and default geometry.
package frame_sample_buffer_pkg;

  localparam int DEFAULT_DEPTH    = 256;
  localparam int DEFAULT_SAMPLE_W = 16;

  localparam logic [2:0] ADDR_STATUS    = 3'd0;
  localparam logic [2:0] ADDR_DATA      = 3'd1;
  localparam logic [2:0] ADDR_THRESHOLD = 3'd2;
  localparam logic [2:0] ADDR_CONTROL   = 3'd3;
  localparam logic [2:0] ADDR_LEVEL     = 3'd4;
  localparam logic [2:0] ADDR_OVF_CNT   = 3'd5;

  localparam int STATUS_OVF_BIT     = 31;
  localparam int STATUS_IRQ_BIT     = 30;
  localparam int STATUS_CLR_IRQ_BIT = 0;
  localparam int STATUS_CLR_OVF_BIT = 1;
  localparam int CTRL_ENABLE_BIT    = 0;
  localparam int CTRL_FLUSH_BIT     = 1;

endpackage

// File: rtl/frame_sample_buffer_sample_fifo.sv
// Single-clock FIFO with combinational head read; callers never push when full
// without a pop, nor pop when empty. level_next exposes the post-edge occupancy.
module sample_fifo #(
  parameter int DEPTH = 256,
  parameter int W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     level_next,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Pointers are AW bits wide, so wrap modulo DEPTH is implicit.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= din;
  end

  assign dout       = mem[rd_ptr_q];
  assign level      = level_q;
  assign level_next = level_d;
  assign full       = (level_q == LW'(DEPTH));
  assign empty      = (level_q == '0);

endmodule

// File: rtl/frame_sample_buffer.sv
// Tick-driven ADC capture FIFO with frame-ready irq and Avalon-MM drain port.
// Optional dropped-sample counter at address 5 when FRAME_BUF_OVF_CNT_EN is defined.
module frame_sample_buffer
  import frame_sample_buffer_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int SAMPLE_W = DEFAULT_SAMPLE_W
) (
  input  logic                csi_clk,
  input  logic                rsi_reset_n,
  input  logic                tick_in,
  input  logic [SAMPLE_W-1:0] adc_sample,
  output logic                irq,
  input  logic                avs_s0_write,
  input  logic                avs_s0_read,
  input  logic [2:0]          avs_s0_address,
  input  logic [31:0]         avs_s0_writedata,
  output logic [31:0]         avs_s0_readdata
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic                enable_q, enable_d;
  logic [LW-1:0]       threshold_q, threshold_d;
  logic                irq_q, irq_d;
  logic                overflow_q, overflow_d;
  logic [31:0]         readdata_q, readdata_d;

  logic                wr_status, wr_thr, wr_ctrl, rd_data;
  logic                flush, fifo_push, fifo_pop, drop;
  logic [SAMPLE_W-1:0] fifo_dout;
  logic [LW-1:0]       fifo_level, fifo_level_next;
  logic                fifo_full, fifo_empty;
  logic [31:0]         ovf_cnt_rd;

  always_comb begin
    wr_status = avs_s0_write && (avs_s0_address == ADDR_STATUS);
    wr_thr    = avs_s0_write && (avs_s0_address == ADDR_THRESHOLD);
    wr_ctrl   = avs_s0_write && (avs_s0_address == ADDR_CONTROL);
    rd_data   = avs_s0_read  && (avs_s0_address == ADDR_DATA);
    flush     = wr_ctrl && avs_s0_writedata[CTRL_FLUSH_BIT];
    // A flush discards both a same-cycle tick and a same-cycle pop.
    fifo_pop  = rd_data && !fifo_empty && !flush;
    fifo_push = tick_in && enable_q && (!fifo_full || fifo_pop) && !flush;
    drop      = tick_in && enable_q && fifo_full && !fifo_pop && !flush;
  end

  sample_fifo #(
    .DEPTH (DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk        (csi_clk),
    .rst_n      (rsi_reset_n),
    .flush      (flush),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .din        (adc_sample),
    .dout       (fifo_dout),
    .level      (fifo_level),
    .level_next (fifo_level_next),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    enable_d    = enable_q;
    threshold_d = threshold_q;
    irq_d       = irq_q;
    overflow_d  = overflow_q;

    if (wr_ctrl) enable_d = avs_s0_writedata[CTRL_ENABLE_BIT];

    if (wr_thr) begin
      if (avs_s0_writedata == 32'd0)
        threshold_d = LW'(1);
      else if (avs_s0_writedata > 32'(DEPTH))
        threshold_d = LW'(DEPTH);
      else
        threshold_d = avs_s0_writedata[LW-1:0];
    end

    // Clears are applied first so a same-cycle set condition wins.
    if (wr_status && avs_s0_writedata[STATUS_CLR_IRQ_BIT]) irq_d = 1'b0;
    if (enable_q && (fifo_level_next >= threshold_q))      irq_d = 1'b1;

    if (wr_status && avs_s0_writedata[STATUS_CLR_OVF_BIT]) overflow_d = 1'b0;
    if (drop)                                              overflow_d = 1'b1;
  end

`ifdef FRAME_BUF_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (wr_status && avs_s0_writedata[STATUS_CLR_OVF_BIT]) ovf_cnt_d = '0;
    if (drop && (ovf_cnt_d != 16'hFFFF))                   ovf_cnt_d = ovf_cnt_d + 16'd1;
  end

  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) ovf_cnt_q <= '0;
    else              ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt_rd = {16'd0, ovf_cnt_q};
`else
  assign ovf_cnt_rd = 32'd0;
`endif

  always_comb begin
    readdata_d = '0;
    if (avs_s0_read) begin
      case (avs_s0_address)
        ADDR_STATUS: begin
          readdata_d                 = 32'(fifo_level);
          readdata_d[STATUS_OVF_BIT] = overflow_q;
          readdata_d[STATUS_IRQ_BIT] = irq_q;
        end
        ADDR_DATA:      readdata_d = fifo_empty ? 32'd0 : 32'($signed(fifo_dout));
        ADDR_THRESHOLD: readdata_d = 32'(threshold_q);
        ADDR_CONTROL:   readdata_d = {31'd0, enable_q};
        ADDR_LEVEL:     readdata_d = 32'(fifo_level);
        ADDR_OVF_CNT:   readdata_d = ovf_cnt_rd;
        default:        readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) begin
      enable_q    <= 1'b0;
      threshold_q <= LW'(DEPTH);
      irq_q       <= 1'b0;
      overflow_q  <= 1'b0;
      readdata_q  <= '0;
    end else begin
      enable_q    <= enable_d;
      threshold_q <= threshold_d;
      irq_q       <= irq_d;
      overflow_q  <= overflow_d;
      readdata_q  <= readdata_d;
    end
  end

  assign irq             = irq_q;
  assign avs_s0_readdata = readdata_q;

endmodule

// File: tb/tb_frame_sample_buffer.sv
// Randomized and directed bench for frame_sample_buffer against a queue-based
// reference model of the register map and capture rules.
module tb_frame_sample_buffer;

  localparam int DEPTH = 256;

  logic        csi_clk = 1'b0;
  logic        rsi_reset_n = 1'b0;
  logic        tick_in = 1'b0;
  logic [15:0] adc_sample = '0;
  logic        irq;
  logic        avs_s0_write = 1'b0;
  logic        avs_s0_read = 1'b0;
  logic [2:0]  avs_s0_address = '0;
  logic [31:0] avs_s0_writedata = '0;
  logic [31:0] avs_s0_readdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] mq[$];
  bit          m_en, m_irq, m_ovf;
  int          m_thr, m_cnt;
  logic [31:0] exp_rd;

  always #5 csi_clk = ~csi_clk;

  frame_sample_buffer #(.DEPTH(DEPTH), .SAMPLE_W(16)) dut (
    .csi_clk          (csi_clk),
    .rsi_reset_n      (rsi_reset_n),
    .tick_in          (tick_in),
    .adc_sample       (adc_sample),
    .irq              (irq),
    .avs_s0_write     (avs_s0_write),
    .avs_s0_read      (avs_s0_read),
    .avs_s0_address   (avs_s0_address),
    .avs_s0_writedata (avs_s0_writedata),
    .avs_s0_readdata  (avs_s0_readdata)
  );

  task automatic model_reset();
    mq.delete();
    m_en = 0; m_irq = 0; m_ovf = 0; m_thr = DEPTH; m_cnt = 0; exp_rd = 0;
  endtask

  task automatic model_step(input logic t, input logic [15:0] s, input logic w,
                            input logic r, input logic [2:0] a, input logic [31:0] d);
    bit flush, dropped;
    int v;
    exp_rd = 0;
    dropped = 0;
    if (r) begin
      case (a)
        3'd0: exp_rd = {m_ovf, m_irq, 30'(mq.size())};
        3'd1: if (mq.size() > 0) begin v = $signed(mq[0]); exp_rd = v; end
        3'd2: exp_rd = m_thr;
        3'd3: exp_rd = {31'd0, m_en};
        3'd4: exp_rd = mq.size();
`ifdef FRAME_BUF_OVF_CNT_EN
        3'd5: exp_rd = m_cnt;
`endif
        default: exp_rd = 0;
      endcase
    end
    flush = w && (a == 3'd3) && d[1];
    if (flush) mq.delete();
    else begin
      if (r && (a == 3'd1) && (mq.size() > 0)) void'(mq.pop_front());
      if (t && m_en) begin
        if (mq.size() < DEPTH) mq.push_back(s);
        else dropped = 1;
      end
    end
    if (w && (a == 3'd0) && d[0]) m_irq = 0;
    if (w && (a == 3'd0) && d[1]) begin m_ovf = 0; m_cnt = 0; end
    if (dropped) begin m_ovf = 1; if (m_cnt < 65535) m_cnt++; end
    if (m_en && (mq.size() >= m_thr)) m_irq = 1;
    if (w && (a == 3'd2)) m_thr = (d == 0) ? 1 : ((d > DEPTH) ? DEPTH : int'(d));
    if (w && (a == 3'd3)) m_en = d[0];
  endtask

  // One bus cycle: entered and left on a falling edge.
  task automatic step(input logic t, input logic [15:0] s, input logic w,
                      input logic r, input logic [2:0] a, input logic [31:0] d);
    tick_in = t; adc_sample = s; avs_s0_write = w; avs_s0_read = r;
    avs_s0_address = a; avs_s0_writedata = d;
    model_step(t, s, w, r, a, d);
    @(posedge csi_clk);
    @(negedge csi_clk);
    tick_in = 0; avs_s0_write = 0; avs_s0_read = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d); step(0, 0, 1, 0, a, d); endtask
  task automatic rd(input logic [2:0] a);                      step(0, 0, 0, 1, a, 0); endtask
  task automatic tick(input logic [15:0] s);                   step(1, s, 0, 0, 0, 0); endtask

  task automatic apply_reset();
    rsi_reset_n = 0;
    step(0, 0, 0, 0, 0, 0);
    model_reset();
    rsi_reset_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (irq !== 1'b0 || avs_s0_readdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_out: irq=%b rd=%h required irq=0 rd=0", irq, avs_s0_readdata);
    end
    rd(3'd0);
    n_checks++;
    if (avs_s0_readdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_status: got %h required 0", avs_s0_readdata);
    end
    rd(3'd2);
    n_checks++;
    if (avs_s0_readdata !== 32'd256) begin
      n_fail++; $display("FAIL reset_threshold: got %h required 100", avs_s0_readdata);
    end
    rd(3'd3);
    n_checks++;
    if (avs_s0_readdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_control: got %h required 0", avs_s0_readdata);
    end
  endtask

  task automatic test_frame();
    logic [15:0] smp [4];
    logic [31:0] want [4];
    smp  = '{16'h0001, 16'h0002, 16'hFFFE, 16'h7FFF};
    want = '{32'h1, 32'h2, 32'hFFFFFFFE, 32'h00007FFF};
    wr(3'd2, 4);
    wr(3'd3, 1);
    for (int i = 0; i < 4; i++) begin
      tick(smp[i]);
      n_checks++;
      if (irq !== (i == 3)) begin
        n_fail++; $display("FAIL frame_irq_%0d: got %b required %b", i, irq, (i == 3));
      end
    end
    rd(3'd4);
    n_checks++;
    if (avs_s0_readdata !== 32'd4) begin
      n_fail++; $display("FAIL frame_level: got %h required 4", avs_s0_readdata);
    end
    for (int i = 0; i < 4; i++) begin
      rd(3'd1);
      n_checks++;
      if (avs_s0_readdata !== want[i]) begin
        n_fail++; $display("FAIL frame_data_%0d: got %h required %h", i, avs_s0_readdata, want[i]);
      end
    end
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL frame_irq_sticky: got %b required 1", irq);
    end
    wr(3'd0, 1);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL frame_irq_clear: got %b required 0", irq);
    end
  endtask

  task automatic test_empty_read();
    rd(3'd1);
    n_checks++;
    if (avs_s0_readdata !== 32'd0) begin
      n_fail++; $display("FAIL empty_data: got %h required 0", avs_s0_readdata);
    end
    rd(3'd4);
    n_checks++;
    if (avs_s0_readdata !== 32'd0) begin
      n_fail++; $display("FAIL empty_level: got %h required 0", avs_s0_readdata);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] want_cnt;
`ifdef FRAME_BUF_OVF_CNT_EN
    want_cnt = 32'd3;
`else
    want_cnt = 32'd0;
`endif
    for (int i = 0; i < DEPTH + 3; i++) tick(16'($urandom));
    rd(3'd0);
    n_checks++;
    if (avs_s0_readdata !== 32'hC000_0100) begin
      n_fail++; $display("FAIL ovf_status: got %h required c0000100", avs_s0_readdata);
    end
    rd(3'd5);
    n_checks++;
    if (avs_s0_readdata !== want_cnt) begin
      n_fail++; $display("FAIL ovf_count: got %h required %h", avs_s0_readdata, want_cnt);
    end
    wr(3'd0, 2);
    rd(3'd0);
    n_checks++;
    if (avs_s0_readdata !== 32'h4000_0100) begin
      n_fail++; $display("FAIL ovf_clear: got %h required 40000100", avs_s0_readdata);
    end
    rd(3'd5);
    n_checks++;
    if (avs_s0_readdata !== 32'd0) begin
      n_fail++; $display("FAIL ovf_count_clear: got %h required 0", avs_s0_readdata);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] head;
    head = $signed(mq[0]);
    step(1, 16'hA5A5, 0, 1, 3'd1, 0);
    n_checks++;
    if (avs_s0_readdata !== head) begin
      n_fail++; $display("FAIL full_pp_data: got %h required %h", avs_s0_readdata, head);
    end
    rd(3'd0);
    n_checks++;
    if (avs_s0_readdata !== 32'h4000_0100) begin
      n_fail++; $display("FAIL full_pp_status: got %h required 40000100", avs_s0_readdata);
    end
  endtask

  task automatic test_irq_clear_race();
    wr(3'd3, 3);
    wr(3'd0, 3);
    wr(3'd2, 3);
    tick(16'h0011);
    tick(16'h0022);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL race_pre_irq: got %b required 0", irq);
    end
    step(1, 16'h0033, 1, 0, 3'd0, 1);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL race_set_wins: got %b required 1", irq);
    end
  endtask

  task automatic test_threshold_flush();
    wr(3'd2, 0);
    rd(3'd2);
    n_checks++;
    if (avs_s0_readdata !== 32'd1) begin
      n_fail++; $display("FAIL thr_zero: got %h required 1", avs_s0_readdata);
    end
    wr(3'd2, 1000);
    rd(3'd2);
    n_checks++;
    if (avs_s0_readdata !== 32'd256) begin
      n_fail++; $display("FAIL thr_clamp: got %h required 100", avs_s0_readdata);
    end
    wr(3'd3, 3);
    rd(3'd4);
    n_checks++;
    if (avs_s0_readdata !== 32'd0 || irq !== 1'b1) begin
      n_fail++; $display("FAIL flush: level=%h irq=%b required level=0 irq=1", avs_s0_readdata, irq);
    end
  endtask

  task automatic test_reset_midframe();
    wr(3'd2, 8);
    for (int i = 0; i < 5; i++) tick(16'(i + 1));
    apply_reset();
    rd(3'd4);
    n_checks++;
    if (avs_s0_readdata !== 32'd0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL midreset: level=%h irq=%b required 0/0", avs_s0_readdata, irq);
    end
  endtask

  task automatic test_random();
    logic t, w, r;
    logic [2:0] a;
    logic [31:0] d;
    wr(3'd3, 1);
    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 9) < 4);
      w = !r && ($urandom_range(0, 19) == 0);
      a = r ? ($urandom_range(0, 3) == 0 ? 3'($urandom) : 3'd1) : 3'($urandom_range(0, 3));
      d = $urandom;
      if (w && a == 3'd2) d = $urandom_range(0, 300);
      if (w && a == 3'd3) d = {30'd0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) != 0)};
      step(t, 16'($urandom), w, r, a, d);
      n_checks++;
      if (avs_s0_readdata !== exp_rd || irq !== m_irq) begin
        n_fail++;
        $display("FAIL random_%0d: rd=%h irq=%b required rd=%h irq=%b", i, avs_s0_readdata, irq, exp_rd, m_irq);
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge csi_clk);
    test_reset();
    test_frame();
    test_empty_read();
    test_overflow();
    test_full_push_pop();
    test_irq_clear_race();
    test_threshold_flush();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
